// File: rtl/lift_pkg.sv
// Shared definitions for the SCAN lift controller family.
package lift_pkg;

  // Direction encoding shared with the fixed 4-floor lift FSM.
  localparam logic [1:0] UP   = 2'b00;
  localparam logic [1:0] DOWN = 2'b01;
  localparam logic [1:0] STAY = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  // Reverse a travel direction (UP <-> DOWN).
  function automatic logic [1:0] flip_dir(input logic [1:0] d);
    return (d == UP) ? DOWN : UP;
  endfunction

endpackage

// File: rtl/lift_req_reg.sv
// One class of pending floor requests, plus "any pending above/below floor" reductions.
module lift_req_reg #(
  parameter int NUM_FLOORS = 4,
  parameter int FW         = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] set_i,
  input  logic [NUM_FLOORS-1:0] clr_i,
  input  logic [FW-1:0]         floor_i,
  output logic [NUM_FLOORS-1:0] pend_o,
  output logic                  above_o,
  output logic                  below_o
);

  logic [NUM_FLOORS-1:0] pend_q;
  logic [NUM_FLOORS-1:0] pend_d;
  logic [NUM_FLOORS-1:0] above_v;
  logic [NUM_FLOORS-1:0] below_v;

  // Latch new requests; a service clear in the same cycle wins over a set.
  always_comb begin
    pend_d = (pend_q | set_i) & ~clr_i;
  end

  // Pending register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Per-floor strictly-above / strictly-below masks relative to floor_i.
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_cmp
    assign above_v[gi] = pend_q[gi] && (gi > int'(floor_i));
    assign below_v[gi] = pend_q[gi] && (gi < int'(floor_i));
  end

  assign pend_o  = pend_q;
  assign above_o = |above_v;
  assign below_o = |below_v;

endmodule

// File: rtl/lift_scan_ctrl.sv
// Single-car SCAN elevator controller: latches calls, sweeps, stops, dwells, reverses.
module lift_scan_ctrl
  import lift_pkg::*;
#(
  parameter int  NUM_FLOORS  = 4,
  parameter int  MOVE_CYCLES = 4,
  parameter int  DOOR_CYCLES = 8,
  localparam int FW          = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_dn_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  output logic [FW-1:0]         floor,
  output logic [1:0]            dir,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] up_lamp,
  output logic [NUM_FLOORS-1:0] dn_lamp,
  output logic [NUM_FLOORS-1:0] car_lamp
);

  localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  // No up call from the top floor, no down call from the ground floor.
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  state_t          state_q, state_d;
  logic [FW-1:0]   floor_q, floor_d;
  logic [1:0]      tdir_q, tdir_d;
  logic [1:0]      dir_q, dir_d;
  logic            door_q, door_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic                  arrive, here, hall_match, stop, ahead, behind;
  logic                  svc_up, svc_dn, do_clr, absorb;
  logic [FW-1:0]         f_step, eval_f;
  logic [NUM_FLOORS-1:0] f_onehot;
  logic [NUM_FLOORS-1:0] up_clr, dn_clr, car_clr;
  logic                  up_above, up_below, dn_above, dn_below, car_above, car_below;

  // Decision floor: the floor being arrived at on a step edge, else the current floor.
  always_comb begin
    arrive = (state_q == MOVE) && (cnt_q == CW'(MOVE_CYCLES - 1));
    f_step = (tdir_q == UP) ? floor_q + FW'(1) : floor_q - FW'(1);
    eval_f = arrive ? f_step : floor_q;
  end

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_onehot
    assign f_onehot[gi] = (gi == int'(eval_f));
  end

  lift_req_reg #(.NUM_FLOORS(NUM_FLOORS), .FW(FW)) u_up (
    .clk(clk), .rst_n(rst_n), .set_i(hall_up_req & UP_MASK), .clr_i(up_clr),
    .floor_i(eval_f), .pend_o(up_lamp), .above_o(up_above), .below_o(up_below)
  );
  lift_req_reg #(.NUM_FLOORS(NUM_FLOORS), .FW(FW)) u_dn (
    .clk(clk), .rst_n(rst_n), .set_i(hall_dn_req & DN_MASK), .clr_i(dn_clr),
    .floor_i(eval_f), .pend_o(dn_lamp), .above_o(dn_above), .below_o(dn_below)
  );
  lift_req_reg #(.NUM_FLOORS(NUM_FLOORS), .FW(FW)) u_car (
    .clk(clk), .rst_n(rst_n), .set_i(car_req), .clr_i(car_clr),
    .floor_i(eval_f), .pend_o(car_lamp), .above_o(car_above), .below_o(car_below)
  );

  // Ahead/behind in travel direction and the service set at the decision floor.
  always_comb begin
    if (tdir_q == UP) begin
      ahead  = up_above | dn_above | car_above;
      behind = up_below | dn_below | car_below;
    end else begin
      ahead  = up_below | dn_below | car_below;
      behind = up_above | dn_above | car_above;
    end
    here       = |((up_lamp | dn_lamp | car_lamp) & f_onehot);
    hall_match = (tdir_q == UP) ? |(up_lamp & f_onehot) : |(dn_lamp & f_onehot);
    stop       = |(car_lamp & f_onehot) | hall_match | !ahead;
    // At a turnaround point both hall directions are served.
    svc_up     = (tdir_q == UP)   || !ahead;
    svc_dn     = (tdir_q == DOWN) || !ahead;
    absorb     = |(f_onehot & (car_req
                               | (hall_up_req & UP_MASK & {NUM_FLOORS{svc_up}})
                               | (hall_dn_req & DN_MASK & {NUM_FLOORS{svc_dn}})));
  end

  // Service-clear vectors, only at the decision floor.
  always_comb begin
    car_clr = do_clr             ? f_onehot : '0;
    up_clr  = (do_clr && svc_up) ? f_onehot : '0;
    dn_clr  = (do_clr && svc_dn) ? f_onehot : '0;
  end

  // Next-state, floor, travel direction and registered-output decode.
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    tdir_d  = tdir_q;
    cnt_d   = cnt_q;
    do_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (here) begin
          state_d = DOOR;
          do_clr  = 1'b1;
          if (!ahead) tdir_d = flip_dir(tdir_q);
        end else if (ahead) begin
          state_d = MOVE;
        end else if (behind) begin
          state_d = MOVE;
          tdir_d  = flip_dir(tdir_q);
        end
      end
      MOVE: begin
        if (arrive) begin
          floor_d = f_step;
          cnt_d   = '0;
          if (stop) begin
            state_d = DOOR;
            do_clr  = 1'b1;
            if (!ahead) tdir_d = flip_dir(tdir_q);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOOR: begin
        // Calls at this floor that the open door already serves are swallowed.
        do_clr = 1'b1;
        if (absorb) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DOOR_CYCLES - 1)) begin
          cnt_d = '0;
          if (ahead) begin
            state_d = MOVE;
          end else if (behind) begin
            state_d = MOVE;
            tdir_d  = flip_dir(tdir_q);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    dir_d  = (state_d == MOVE) ? tdir_d : STAY;
    door_d = (state_d == DOOR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      floor_q <= '0;
      tdir_q  <= UP;
      dir_q   <= STAY;
      door_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      tdir_q  <= tdir_d;
      dir_q   <= dir_d;
      door_q  <= door_d;
      cnt_q   <= cnt_d;
    end
  end

  assign floor     = floor_q;
  assign dir       = dir_q;
  assign door_open = door_q;

endmodule

// File: doc/lift_scan_ctrl.md
# lift_scan_ctrl

Parametrised single-car elevator controller for NUM_FLOORS floors using SCAN (collective) scheduling. Hall up/down calls and car calls are latched into pending-request registers. The car keeps moving in its current direction while requests lie ahead, stops at qualifying floors, holds the door for a fixed dwell, and reverses or idles when nothing lies ahead. It is the next generation of the fixed 4-floor lift FSM and keeps that block's UP/DOWN/STAY direction encoding.

## Interface
Parameters:
- NUM_FLOORS, 4: floor count, ≥2; floors numbered 0..NUM_FLOORS-1.
- MOVE_CYCLES, 4: clock cycles to travel one floor, ≥1.
- DOOR_CYCLES, 8: door-open dwell in cycles, ≥1.
- FW (localparam): $clog2(NUM_FLOORS).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- hall_up_req  in  NUM_FLOORS  up-call pulse or level per floor; bit NUM_FLOORS-1 ignored.
- hall_dn_req  in  NUM_FLOORS  down-call per floor; bit 0 ignored.
- car_req  in  NUM_FLOORS  in-car floor button per floor.
- floor  out  FW  current floor, registered.
- dir  out  2  UP=2'b00, DOWN=2'b01, STAY=2'b10; registered.
- door_open  out  1  door held open.
- up_lamp, dn_lamp, car_lamp  out  NUM_FLOORS each  pending-request registers.

## Operation
- Reset values: floor=0, dir=STAY, door_open=0, all lamps 0, state IDLE, travel direction register tdir=UP.
- Latching: each input bit ORs into its pending bit on the next edge. Ignored bits never set. Clear-on-service beats set in the same cycle.
- "Ahead" means any pending bit of any class strictly beyond the current floor in tdir.
- States:
  - IDLE: dir=STAY, door closed.
    - Any pending bit at the current floor → DOOR, service-clear.
    - Else if requests lie ahead in tdir → MOVE in tdir.
    - Else if requests lie behind → flip tdir, MOVE.
    - Else stay in IDLE.
  - MOVE: dir=tdir, door closed. The counter starts at 0 on entry. On the edge where counter==MOVE_CYCLES-1, floor steps ±1 and the stop decision is made on the new floor:
    - Stop if car_lamp[f] is set, or the tdir-matching hall lamp at f is set, or nothing lies ahead of f (including the end floors).
    - Stop → DOOR with service-clear. Otherwise stay in MOVE with the counter reset.
  - DOOR: dir=STAY, door_open=1, dwell counter starts at 0.
    - New requests at the current floor that match the service set are absorbed (not latched) and restart the dwell counter.
    - On the edge where counter==DOOR_CYCLES-1: requests ahead → MOVE in tdir; else requests behind → flip tdir, MOVE; else IDLE.
- Service-clear at floor f:
  - Clears car_lamp[f] and the hall lamp at f matching tdir.
  - If nothing lies ahead of f, also clears the opposite hall lamp at f and flips tdir.
  - In IDLE with nothing ahead or behind, clears all lamps at f.
- The car never stops at the floor it is leaving. A request there during MOVE is latched and served later.

## Timing
- Request pulse in cycle t → lamp visible at t+1. From IDLE, dir changes to UP/DOWN at t+2.
- Each floor takes exactly MOVE_CYCLES cycles in MOVE. floor, dir and door_open change on the same edge at arrival-with-stop.
- Door dwell is exactly DOOR_CYCLES cycles of door_open=1 unless restarted by an absorbed request.
- Reset asserted in any state: all outputs take their reset values on the next edge. Any in-flight move is abandoned.

## Structure
- Shared package lift_pkg holds:
  - dir encoding constants UP/DOWN/STAY (common with the existing lift FSM).
  - state enum IDLE/MOVE/DOOR.
- One natural sub-module, lift_req_reg: a NUM_FLOORS-wide pending register with set vector, clear vector (clear wins) and an "ahead/behind of floor f in dir d" reduction. Instantiated three times for the up, down and car request classes.

## Test plan
- Reset, then car_req[2] pulse at floor 0 (MOVE_CYCLES=4, DOOR_CYCLES=8) → dir=UP at t+2; floor=1 at t+6; floor=2, door_open=1, car_lamp[2]=0 at t+10; door_open=0 and dir=STAY at t+18.
- Moving up from 0 with car_lamp[3] set, then hall_dn_req[2] pulse → car passes floor 2 without stopping, stops at 3, reverses, stops at 2; dn_lamp[2] clears on that arrival.
- At floor 0, hall_up_req[0] and hall_dn_req[0] pulsed together → up request latched, down request never latched; door opens without movement.
- During DOOR at floor 1 with tdir=UP, car_req[1] pulsed at dwell count 5 → dwell restarts; door_open stays 1 for 8 more cycles.
- Reset asserted mid-MOVE between floors 1 and 2 → next edge: floor=0, dir=STAY, all lamps 0.
- NUM_FLOORS=8 regression: random request pulses → every set lamp is eventually cleared, the car never passes a car_lamp floor in its travel direction, and floor never leaves 0..7.
